// File: rtl/time_set_controller.sv
// mm:ss time counter with start/stop and front-panel minute/second setting.
// Owns the four BCD digits, the 1 Hz tick divider and the set-mode blink timer.
module time_set_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_startstop,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_unit,
    output logic [3:0] sec_tens,
    output logic [3:0] min_unit,
    output logic [3:0] min_tens,
    output logic [3:0] blank,
    output logic       running,
    output logic       led,
    output logic [1:0] mode_state
);

    // state   | meaning
    // IDLE    | time frozen
    // RUN     | time advances on each tick
    // SET_MIN | inc bumps minutes, minute digits blink
    // SET_SEC | inc bumps seconds, second digits blink
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    state_t        state_q, state_d;
    logic          running_q;
    logic          ss_prev_q, mode_prev_q, inc_prev_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          led_q, led_d;
    logic [3:0]    sec_u_q, sec_t_q, min_u_q, min_t_q;
    logic [3:0]    sec_u_d, sec_t_d, min_u_d, min_t_d;

    logic ev_ss, ev_mode, ev_inc, inc_apply, tick, blink_clr;

    assign ev_ss     = btn_startstop & ~ss_prev_q;
    assign ev_mode   = btn_mode & ~mode_prev_q;
    assign ev_inc    = btn_inc & ~inc_prev_q;
    // Only the highest-priority event may act; inc is meaningful only in set states.
    assign inc_apply = ev_inc & ~ev_ss & ~ev_mode & state_q[1];
    assign tick      = (state_q == RUN) && (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ev_ss)        state_d = RUN;
                else if (ev_mode) state_d = SET_MIN;
            end
            RUN: begin
                if (ev_ss) state_d = IDLE;
            end
            SET_MIN: begin
                if (ev_ss)        state_d = IDLE;
                else if (ev_mode) state_d = SET_SEC;
            end
            SET_SEC: begin
                if (ev_ss || ev_mode) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_state = state_q;
        running    = running_q;
        led        = led_q;
        sec_unit   = sec_u_q;
        sec_tens   = sec_t_q;
        min_unit   = min_u_q;
        min_tens   = min_t_q;
        blank      = 4'b0000;
        case (state_q)
            SET_MIN: blank = {phase_q, phase_q, 2'b00};
            SET_SEC: blank = {2'b00, phase_q, phase_q};
            default: blank = 4'b0000;
        endcase
    end

    always_comb begin
        tick_cnt_d = '0;
        if (state_q == RUN && state_d == RUN)
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        led_d = tick ? ~led_q : led_q;
    end

    // Blink restarts visible on entry to a set state and after every applied inc.
    assign blink_clr = ~state_d[1] | (state_d != state_q) | inc_apply;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_clr) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        if (tick) begin
            sec_u_d = sec_u_q + 4'd1;
            if (sec_u_q == 4'd9) begin
                sec_u_d = 4'd0;
                sec_t_d = sec_t_q + 4'd1;
                if (sec_t_q == 4'd5) begin
                    sec_t_d = 4'd0;
                    min_u_d = min_u_q + 4'd1;
                    if (min_u_q == 4'd9) begin
                        min_u_d = 4'd0;
                        min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
                    end
                end
            end
        end else if (inc_apply && state_q == SET_MIN) begin
            min_u_d = min_u_q + 4'd1;
            if (min_u_q == 4'd9) begin
                min_u_d = 4'd0;
                min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
            end
        end else if (inc_apply && state_q == SET_SEC) begin
            sec_u_d = sec_u_q + 4'd1;
            if (sec_u_q == 4'd9) begin
                sec_u_d = 4'd0;
                sec_t_d = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_prev_q   <= 1'b1;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            led_q       <= 1'b0;
            sec_u_q     <= 4'd0;
            sec_t_q     <= 4'd0;
            min_u_q     <= 4'd0;
            min_t_q     <= 4'd0;
        end else begin
            ss_prev_q   <= btn_startstop;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            sec_u_q     <= sec_u_d;
            sec_t_q     <= sec_t_d;
            min_u_q     <= min_u_d;
            min_t_q     <= min_t_d;
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random button
// activity, compared every cycle against a seconds-based behavioural model.
module tb_time_set_controller;

    logic       clk, rst;
    logic       btn_startstop, btn_mode, btn_inc;
    logic [3:0] sec_unit, sec_tens, min_unit, min_tens, blank;
    logic       running, led;
    logic [1:0] mode_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: time as total seconds, state as 0..3, ages in cycles since entry.
    int m_st, m_t, m_age, m_bage;
    bit m_led, p_ss, p_md, p_inc;

    time_set_controller #(.TICK_DIV(10), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .btn_startstop(btn_startstop), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_unit(sec_unit), .sec_tens(sec_tens), .min_unit(min_unit), .min_tens(min_tens),
        .blank(blank), .running(running), .led(led), .mode_state(mode_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_age = 0; m_bage = 0; m_led = 0;
        p_ss = 1; p_md = 1; p_inc = 1;
    endtask

    task automatic model_step();
        bit e_ss, e_md, e_inc, tick, inc_ok;
        int old, ns;
        e_ss  = btn_startstop && !p_ss;
        e_md  = btn_mode && !p_md;
        e_inc = btn_inc && !p_inc;
        p_ss = btn_startstop; p_md = btn_mode; p_inc = btn_inc;
        old    = m_st;
        tick   = (old == 1) && (m_age % 10 == 9);
        inc_ok = e_inc && !e_ss && !e_md && (old >= 2);
        if (tick) begin
            m_t   = (m_t + 1) % 3600;
            m_led = !m_led;
        end
        if (inc_ok && old == 2) m_t = (((m_t / 60) + 1) % 60) * 60 + m_t % 60;
        if (inc_ok && old == 3) m_t = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
        ns = old;
        if (e_ss) ns = (old == 0) ? 1 : 0;
        else if (e_md) ns = (old == 0) ? 2 : (old == 2) ? 3 : (old == 3) ? 0 : old;
        m_age  = (ns == 1) ? ((old == 1) ? m_age + 1 : 0) : 0;
        m_bage = (ns >= 2) ? ((ns != old || inc_ok) ? 0 : m_bage + 1) : 0;
        m_st   = ns;
    endtask

    task automatic check_all();
        int s, m, ph;
        logic [3:0] eb;
        s  = m_t % 60;
        m  = m_t / 60;
        ph = (m_bage / 4) % 2;
        eb = 4'b0000;
        if (m_st == 2 && ph == 1) eb = 4'b1100;
        if (m_st == 3 && ph == 1) eb = 4'b0011;
        chk("state", mode_state, m_st);
        chk("running", running, (m_st == 1));
        chk("led", led, m_led);
        chk("sec_unit", sec_unit, s % 10);
        chk("sec_tens", sec_tens, s / 10);
        chk("min_unit", min_unit, m % 10);
        chk("min_tens", min_tens, m / 10);
        chk("blank", blank, eb);
    endtask

    task automatic cyc(input logic ss, input logic md, input logic inc);
        btn_startstop = ss; btn_mode = md; btn_inc = inc;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic press(input int which);
        cyc(which == 0, which == 1, which == 2);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // From IDLE: walk through both set modes and return to IDLE at mm:ss.
    task automatic set_time(input int m, input int s);
        int nm, ns;
        nm = (m - m_t / 60 + 60) % 60;
        ns = (s - m_t % 60 + 60) % 60;
        press(1);
        for (int i = 0; i < nm; i++) press(2);
        press(1);
        for (int i = 0; i < ns; i++) press(2);
        press(1);
    endtask

    task automatic run_ticks(input int n);
        press(0);
        repeat (n * 10) cyc(1'b0, 1'b0, 1'b0);
        press(0);
    endtask

    initial begin
        int t0;
        logic ss, md, inc;
        rst = 1'b1;
        btn_startstop = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all();
        #2 rst = 1'b0;

        // startstop held through reset release: no event
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("held_no_event", mode_state, 2'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("enter_run", running, 1'b1);
        repeat (9) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_tick_su", sec_unit, 4'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("first_tick_su", sec_unit, 4'd1);
        chk("first_tick_led", led, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        press(0);

        // carries and full wrap
        set_time(0, 8);
        run_ticks(2);
        chk("carry_0010", {min_tens, min_unit, sec_tens, sec_unit}, 16'h0010);
        set_time(0, 59);
        run_ticks(1);
        chk("carry_0100", {min_tens, min_unit, sec_tens, sec_unit}, 16'h0100);
        set_time(9, 59);
        run_ticks(1);
        chk("carry_1000", {min_tens, min_unit, sec_tens, sec_unit}, 16'h1000);
        set_time(59, 58);
        run_ticks(1);
        chk("wrap_5959", {min_tens, min_unit, sec_tens, sec_unit}, 16'h5959);
        run_ticks(1);
        chk("wrap_0000", {min_tens, min_unit, sec_tens, sec_unit}, 16'h0000);

        // set-mode wrap without carry
        press(1);
        for (int i = 0; i < 60; i++) press(2);
        chk("min_wrap", {min_tens, min_unit}, 8'h00);
        press(1);
        for (int i = 0; i < 61; i++) press(2);
        chk("sec_wrap", {min_tens, min_unit, sec_tens, sec_unit}, 16'h0001);
        press(1);
        chk("idle_blank", blank, 4'b0000);

        // blink and inc-forced visibility
        press(1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        chk("blink_off", blank, 4'b1100);
        cyc(1'b0, 1'b0, 1'b1);
        chk("blink_inc_clr", blank, 4'b0000);
        cyc(1'b0, 1'b0, 1'b0);

        // simultaneous events in SET_SEC
        press(1);
        t0 = m_t;
        cyc(1'b1, 1'b1, 1'b1);
        chk("simul_state", mode_state, 2'd0);
        chk("simul_sec", sec_unit, t0 % 10);
        cyc(1'b0, 1'b0, 1'b0);

        // startstop coinciding with a tick
        cyc(1'b1, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        t0 = m_t;
        cyc(1'b1, 1'b0, 1'b0);
        chk("ss_tick_state", mode_state, 2'd0);
        chk("ss_tick_sec", sec_unit, ((t0 + 1) % 60) % 10);
        cyc(1'b0, 1'b0, 1'b0);

        // async reset mid-RUN at 12:34 with mode held
        set_time(12, 34);
        press(0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        btn_mode = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        chk("rst_held_mode", mode_state, 2'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // random button activity
        ss = 0; md = 0; inc = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11) == 0) ss = ~ss;
            if ($urandom_range(5) == 0)  md = ~md;
            if ($urandom_range(2) == 0)  inc = ~inc;
            cyc(ss, md, inc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Mode/sequencing controller for the mm:ss time counter, with start/stop control and manual minute/second setting from three front-panel buttons.
- It owns the four BCD digit registers and generates its own 1 Hz enable. All logic is synchronous to clk; no derived clocks.
- The digit outputs drive the existing four-digit 7-segment display decoder. The blank outputs make the field being set blink.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick (must be >= 2).
- BLINK_DIV, 25000000: clk cycles per blink half-period in set modes (must be >= 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_startstop  in  1  level; already debounced and synchronized to clk
- btn_mode  in  1  level; already debounced and synchronized to clk
- btn_inc  in  1  level; already debounced and synchronized to clk
- sec_unit  out  4  BCD 0..9
- sec_tens  out  4  BCD 0..5
- min_unit  out  4  BCD 0..9
- min_tens  out  4  BCD 0..5
- blank  out  4  per-digit blank: bit0=sec_unit, bit1=sec_tens, bit2=min_unit, bit3=min_tens; 1 = digit off
- running  out  1  1 while in RUN
- led  out  1  toggles on every applied tick
- mode_state  out  2  current state encoding

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-high. It forces:
  - all digits = 0
  - blank = 0000, running = 0, led = 0
  - state = IDLE
  - tick and blink counters = 0, blink phase = 0
  - button history registers = 1, so a button held through reset release produces no event.
- Reset mid-operation: rst may assert in any state; it returns the block to the reset values immediately.
- Button events:
  - An event is a single-cycle rising edge: btn & ~prev, where prev is registered every cycle.
  - The action takes effect at the clk edge that first samples the button high; outputs are registered.
  - Holding a button produces exactly one event.
- Simultaneous events in one cycle: priority is startstop > mode > inc. Only the highest-priority event acts; the others are discarded.
- States (mode_state encoding):
  - IDLE (00): time frozen.
    - startstop -> RUN
    - mode -> SET_MIN
    - inc ignored
  - RUN (01): time advances.
    - startstop -> IDLE
    - mode and inc ignored
  - SET_MIN (10):
    - inc -> minutes +1, wrapping 59 -> 00; seconds untouched
    - mode -> SET_SEC
    - startstop -> IDLE
  - SET_SEC (11):
    - inc -> seconds +1, wrapping 59 -> 00, with no carry into minutes
    - mode -> IDLE
    - startstop -> IDLE
- Tick generation:
  - The tick counter runs only in RUN and is held at 0 in all other states, so the first tick comes TICK_DIV cycles after entering RUN.
  - A tick occurs when the count is TICK_DIV-1; the counter then wraps to 0.
  - On a tick, the time advances one second with BCD carries:
    - sec_unit 9 -> 0 carries into sec_tens
    - sec_tens 5 -> 0 carries into min_unit
    - min_unit 9 -> 0 carries into min_tens
    - 59:59 -> 00:00
  - A tick coinciding with a startstop event in RUN is still applied (the time increments) and the state goes to IDLE.
- led: toggles on each applied tick only; it holds its value outside RUN.
- Blink:
  - The blink counter and phase run only in SET_MIN and SET_SEC. The phase toggles every BLINK_DIV cycles.
  - Counter and phase are cleared to 0 (visible) on entering a set state and on every applied inc event.
  - blank[3:2] = {phase, phase} in SET_MIN; blank[1:0] = {phase, phase} in SET_SEC; all other bits are 0.
  - In IDLE and RUN, blank = 0000.
- Digit invariants: digits never leave their legal BCD ranges, and no out-of-range value is ever output.
- running = (state == RUN), registered together with the state.

Test Plan (TICK_DIV=10, BLINK_DIV=4):
- Reset and first tick: reset with btn_startstop held high, release rst -> state stays IDLE. Release and press startstop -> RUN, running=1, first tick exactly 10 cycles later (sec_unit=1, led=1).
- Full wrap: set 59:58 via set modes, then run 2 ticks -> 59:59, then 00:00. Check each intermediate carry (00:09->00:10, 00:59->01:00, 09:59->10:00).
- Set-mode wrap: from 00:00, mode, then 60 inc presses -> min back to 00. Mode, 61 inc presses -> 00:01 with minutes untouched. Mode -> IDLE, blank=0000.
- Blink: in SET_MIN, blank[3:2] toggles every 4 cycles and blank[1:0] stays 00. An inc press mid-blank-phase forces blank=0000 at the next edge.
- Simultaneous events: in SET_SEC, raise startstop, mode and inc in the same cycle -> IDLE, seconds unchanged. In RUN, a startstop event coinciding with a tick -> time incremented and state IDLE.
- Async reset mid-RUN at 12:34 -> all outputs return to reset values without a clock edge; a held button produces no event after release.
